// File: rtl/wrr_burst_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter:
// FSM state, id-width sizing, one-hot decode and the "bits above" priority mask.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned oh2bin(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

  // The top index has nothing above it, so priority restarts from bit 0 (all-ones mask).
  function automatic logic [31:0] therm_above(input int unsigned idx, input int unsigned n);
    if (idx >= n - 1) return '1;
    return ~((32'd2 << idx) - 32'd1);
  endfunction

endpackage

// File: rtl/wrr_burst_arbiter_rr_pick.sv
// Combinational round-robin pick: lowest requester at/above the pointer mask,
// falling back to the lowest requester overall when the masked set is empty.
module rr_pick
  import arb_pkg::*;
#(
  parameter int  REQ_WIDTH = 5,
  localparam int ID_W      = id_width(REQ_WIDTH)
) (
  input  logic [REQ_WIDTH-1:0] req_i,
  input  logic [REQ_WIDTH-1:0] ptr_i,
  output logic [REQ_WIDTH-1:0] win_oh_o,
  output logic [ID_W-1:0]      win_id_o,
  output logic                 any_o
);

  logic [REQ_WIDTH-1:0] masked;
  logic [REQ_WIDTH-1:0] src;

  assign masked   = req_i & ptr_i;
  assign src      = (|masked) ? masked : req_i;
  // Two's-complement trick isolates the lowest set bit.
  assign win_oh_o = src & (~src + REQ_WIDTH'(1));
  assign win_id_o = ID_W'(oh2bin(32'(win_oh_o)));
  assign any_o    = |req_i;

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter for one shared-memory bank: the winner holds the
// grant for up to w_eff beats (paced by ack) or until it drops req, then priority rotates.
module wrr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int  REQ_WIDTH = 5,
  parameter int  WEIGHT_W  = 4,
  localparam int ID_W      = id_width(REQ_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_WIDTH-1:0]          req,
  input  logic [REQ_WIDTH*WEIGHT_W-1:0] weight,
  input  logic                          ack,
  output logic [REQ_WIDTH-1:0]          gnt,
  output logic [ID_W-1:0]               gnt_id,
  output logic                          gnt_vld,
  output logic [WEIGHT_W-1:0]           credit
);

  state_t               state_q, state_d;
  logic [REQ_WIDTH-1:0] gnt_q, gnt_d;
  logic [REQ_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;

  logic                 busy, owner_req, rel;
  logic [REQ_WIDTH-1:0] ptr_rel, pick_ptr, win_oh;
  logic [ID_W-1:0]      win_id;
  logic                 win_any;
  logic [WEIGHT_W-1:0]  w_eff;

  assign busy      = (state_q == BUSY);
  assign owner_req = |(req & gnt_q);
  assign rel       = busy && ((ack && (credit_q == WEIGHT_W'(1))) || !owner_req);
  assign ptr_rel   = REQ_WIDTH'(therm_above(32'(id_q), unsigned'(REQ_WIDTH)));
  // A releasing owner re-arbitrates this cycle against the already-rotated pointer.
  assign pick_ptr  = rel ? ptr_rel : ptr_q;

  rr_pick #(.REQ_WIDTH(REQ_WIDTH)) u_pick (
    .req_i    (req),
    .ptr_i    (pick_ptr),
    .win_oh_o (win_oh),
    .win_id_o (win_id),
    .any_o    (win_any)
  );

  always_comb begin
    w_eff = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (win_oh[i]) w_eff = weight[i*WEIGHT_W +: WEIGHT_W];
    end
    if (w_eff == '0) w_eff = WEIGHT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    if (!busy || rel) begin
      if (rel) ptr_d = ptr_rel;
      if (win_any) begin
        state_d  = BUSY;
        gnt_d    = win_oh;
        id_d     = win_id;
        credit_d = w_eff;
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        id_d     = '0;
        credit_d = '0;
      end
    end else if (ack) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      id_q     <= '0;
      credit_q <= '0;
      ptr_q    <= '1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign gnt_vld = |gnt_q;
  assign credit  = credit_q;

endmodule
